vga_sync_gen: RTL and testbench

Raster timing generator that sits directly upstream of the switch-driven VGA display stage. It divides the 100 MHz system clock into a pixel-enable tick and runs horizontal/vertical counters for 640x480@60 timing. It produces h_sync, v_sync, display_en and the current pixel coordinates. The colour stage uses display_en to gate its sw_red/sw_green/sw_blue values onto r_port/g_port/b_port, and forwards h_sync/v_sync to the connector.

---
 rtl/vga_sync_gen.sv | 125 ++++++++++++
 tb/tb_vga_sync_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-enable divider plus horizontal/vertical counters with registered sync/blank decodes.
// Optional frame_start output is built when VGA_SYNC_FRAME_START_EN is defined.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       display_en,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel
`ifdef VGA_SYNC_FRAME_START_EN
    ,
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be within 1..16");
    end

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a 1024-wide total still compares correctly
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [3:0]  div_cnt;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        h_last;
    logic        v_last;
    logic        visible;
    logic        in_hs;
    logic        in_vs;

    assign pixel_tick = (div_cnt == DIV_LAST);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign h_ext      = {1'b0, h_cnt};
    assign v_ext      = {1'b0, v_cnt};
    assign visible    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    assign in_hs      = (h_ext >= HS_START) && (h_ext < HS_END);
    assign in_vs      = (v_ext >= VS_START) && (v_ext < VS_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (pixel_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Decodes are registered every clk, so they trail the counters by one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            display_en <= 1'b0;
            x_pixel    <= '0;
            y_pixel    <= '0;
        end else begin
            h_sync     <= !in_hs;
            v_sync     <= !in_vs;
            display_en <= visible;
            x_pixel    <= visible ? h_cnt : 10'd0;
            y_pixel    <= visible ? v_cnt : 10'd0;
        end
    end

`ifdef VGA_SYNC_FRAME_START_EN
    // frame_wrap marks the counter wrap; delaying it once lines the pulse up with x = y = 0 on the outputs.
    logic frame_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_wrap  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_wrap  <= pixel_tick && h_last && v_last;
            frame_start <= frame_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced raster so several frames and random resets fit in a short run.
// Expected outputs are derived from the number of clk edges since reset release.
module tb_vga_sync_gen;

    localparam int D   = 3;
    localparam int HV  = 20;
    localparam int HFP = 3;
    localparam int HS  = 5;
    localparam int HBP = 4;
    localparam int VV  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int F   = D * HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pixel_tick;
    logic       h_sync;
    logic       v_sync;
    logic       display_en;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
`ifdef VGA_SYNC_FRAME_START_EN
    logic       frame_start;
`endif

    vga_sync_gen #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .display_en (display_en),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel)
`ifdef VGA_SYNC_FRAME_START_EN
        ,
        .frame_start(frame_start)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // n = clk edges seen with reset released; outputs after edge n show pixel (n-1)/D.
    function automatic exp_t model(input int n);
        exp_t e;
        int   p, h, v;
        e.tick = ((n % D) == D - 1);
        if (n == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
            e.x = '0; e.y = '0; e.fs = 1'b0;
        end else begin
            p = (n - 1) / D;
            h = p % HT;
            v = (p / HT) % VT;
            e.hs = !(h >= HV + HFP && h < HV + HFP + HS);
            e.vs = !(v >= VV + VFP && v < VV + VFP + VS);
            e.de = (h < HV) && (v < VV);
            e.x  = e.de ? 10'(h) : 10'd0;
            e.y  = e.de ? 10'(v) : 10'd0;
            e.fs = (n > 1) && (((n - 1) % F) == 0);
        end
        return e;
    endfunction

    // Reference process: reset only changes at posedge+2, so sampling at +3 sees the settled state.
    initial begin
        int   n;
        logic r_edge;
        n = 0;
        forever begin
            @(posedge clk);
            r_edge = reset;
            #3;
            if (!reset) n = 0;
            else if (r_edge) n++;
            q.push_back(model(n));
        end
    end

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got 0 entries expected 1 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("pixel_tick", {9'd0, pixel_tick}, {9'd0, e.tick});
                chk("h_sync",     {9'd0, h_sync},     {9'd0, e.hs});
                chk("v_sync",     {9'd0, v_sync},     {9'd0, e.vs});
                chk("display_en", {9'd0, display_en}, {9'd0, e.de});
                chk("x_pixel",    x_pixel,            e.x);
                chk("y_pixel",    y_pixel,            e.y);
`ifdef VGA_SYNC_FRAME_START_EN
                chk("frame_start", {9'd0, frame_start}, {9'd0, e.fs});
`endif
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0;
        run(2);
        #2 reset = 1'b1;
        run(2 * F + 100);
        for (int s = 0; s < 8; s++) begin
            run($urandom_range(3 * F, 1));
            #2 reset = 1'b0;
            run($urandom_range(5, 1));
            #2 reset = 1'b1;
        end
        run(F + 50);
        @(negedge clk);
        #1 done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
